// File: rtl/cdc_chan_pkg.sv
// -----------------------------------------------------------------------------
// cdc_chan_pkg
// Shared definitions for the CDC FIFO channel arbiter:
//   - chan_state_t : sequencer states (RESET, RECOVER, RUN)
//   - MIN_RST_CYCLES / MIN_RECOVER_CYCLES : lower bounds of the FIFO reset
//     sequence timing that the 7-series FIFO primitive tolerates
//   - tag_width()  : width of the source tag prepended to each FIFO word
// -----------------------------------------------------------------------------
package cdc_chan_pkg;

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_RECOVER = 2'd1,
        ST_RUN     = 2'd2
    } chan_state_t;

    localparam int MIN_RST_CYCLES     = 5;
    localparam int MIN_RECOVER_CYCLES = 4;

    // At least one tag bit so the port never collapses to zero width.
    function automatic int tag_width(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/rr_arb.sv
// -----------------------------------------------------------------------------
// rr_arb
// Combinational round-robin grant: the first set bit of valid, searching from
// ptr upward modulo NUM_REQ, becomes the one-hot grant.
// Ports:
//   valid     in  NUM_REQ  request vector
//   ptr       in  TAG_W    highest-priority index (always < NUM_REQ)
//   grant     out NUM_REQ  one-hot grant, zero when nothing is valid
//   grant_idx out TAG_W    binary index of the grant
//   any_valid out 1        at least one request present
// -----------------------------------------------------------------------------
module rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [TAG_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [TAG_W-1:0]   grant_idx,
    output logic               any_valid
);

    logic [TAG_W-1:0] idx;

    // Walk from the farthest offset back to ptr so the closest valid
    // requester is the last one written and therefore wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = TAG_W'((int'(ptr) + k) % NUM_REQ);
            if (valid[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
                any_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdc_chan_arb.sv
// -----------------------------------------------------------------------------
// cdc_chan_arb
// Round-robin arbiter and reset sequencer for a shared dual-clock FIFO write
// port. NUM_REQ valid/ready requesters are multiplexed onto one FIFO write
// port; each word is written as {tag, data}. The FIFO reset sequence
// (RST held, WREN low around it) is generated here. Single clock domain.
//
// Optional feature: define CDC_CHAN_ARB_ERRCNT_EN to build the saturating
// write-error counter; otherwise err_cnt is tied to zero.
//
// Ports:
//   clk              in  1                 FIFO write clock
//   rst              in  1                 synchronous active-high reset
//   flush            in  1                 pulse: re-run FIFO reset sequence
//   req_valid        in  NUM_REQ           per-requester valid
//   req_data         in  NUM_REQ*DATA_W    packed payloads, i at [i*DATA_W +: DATA_W]
//   req_ready        out NUM_REQ           per-requester ready (one-hot or zero)
//   fifo_rst         out 1                 FIFO RST
//   fifo_wren        out 1                 FIFO WREN
//   fifo_di          out DATA_W+TAG_W      FIFO DI = {tag, data}
//   fifo_almostfull  in  1                 FIFO ALMOSTFULL (sole backpressure)
//   fifo_wrerr       in  1                 FIFO WRERR
//   chan_up          out 1                 high while in RUN
//   err_cnt          out 16                write-error count
// -----------------------------------------------------------------------------
module cdc_chan_arb
    import cdc_chan_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int DATA_W         = 32,
    parameter  int RST_CYCLES     = 8,
    parameter  int RECOVER_CYCLES = 4,
    localparam int TAG_W          = tag_width(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        fifo_rst,
    output logic                        fifo_wren,
    output logic [DATA_W+TAG_W-1:0]     fifo_di,
    input  logic                        fifo_almostfull,
    input  logic                        fifo_wrerr,
    output logic                        chan_up,
    output logic [15:0]                 err_cnt
);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("cdc_chan_arb: NUM_REQ must be 2..8");
    end
    if (RST_CYCLES < MIN_RST_CYCLES) begin : g_bad_rst_cycles
        $error("cdc_chan_arb: RST_CYCLES below minimum");
    end
    if (RECOVER_CYCLES < MIN_RECOVER_CYCLES) begin : g_bad_recover_cycles
        $error("cdc_chan_arb: RECOVER_CYCLES below minimum");
    end
    if (DATA_W + TAG_W > 72) begin : g_bad_width
        $error("cdc_chan_arb: DATA_W+TAG_W exceeds FIFO width");
    end

    chan_state_t state, state_d;
    logic [15:0] cnt, cnt_d;

    logic [TAG_W-1:0]   ptr;
    logic [NUM_REQ-1:0] grant;
    logic [TAG_W-1:0]   grant_idx;
    logic               any_valid;
    logic               arb_en;
    logic               xfer;

    logic                    fifo_rst_q;
    logic                    chan_up_q;
    logic                    vld_p1;
    logic [DATA_W+TAG_W-1:0] di_p1;

    // ---- Sequencer -------------------------------------------------------
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            ST_RESET: begin
                if (cnt == 16'(RST_CYCLES - 1)) begin
                    state_d = ST_RECOVER;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end
            ST_RECOVER: begin
                if (cnt == 16'(RECOVER_CYCLES - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
            end
            default: begin
                state_d = ST_RESET;
                cnt_d   = '0;
            end
        endcase
        if (flush) begin
            state_d = ST_RESET;
            cnt_d   = '0;
        end
    end

    // fifo_rst and chan_up are registered from the next state so they switch
    // on the same edge as the state itself without decode glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RESET;
            cnt        <= '0;
            fifo_rst_q <= 1'b1;
            chan_up_q  <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            fifo_rst_q <= (state_d == ST_RESET);
            chan_up_q  <= (state_d == ST_RUN);
        end
    end

    // ---- Arbitration (combinational, p0) ---------------------------------
    rr_arb #(
        .NUM_REQ (NUM_REQ),
        .TAG_W   (TAG_W)
    ) u_rr_arb (
        .valid     (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_valid (any_valid)
    );

    // A flush cancels the transfer in its own cycle.
    assign arb_en    = (state == ST_RUN) && !fifo_almostfull && !flush;
    assign req_ready = arb_en ? grant : '0;
    assign xfer      = arb_en && any_valid;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // ---- Output register (p1) --------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            di_p1  <= '0;
        end else begin
            vld_p1 <= xfer;
            if (xfer) begin
                di_p1 <= {grant_idx, req_data[grant_idx*DATA_W +: DATA_W]};
            end
        end
    end

    // A word already in the output register is dropped when flush arrives,
    // which also guarantees WREN is low the cycle before RST rises.
    assign fifo_wren = vld_p1 && !flush;
    assign fifo_di   = di_p1;
    assign fifo_rst  = fifo_rst_q;
    assign chan_up   = chan_up_q;

    // ---- Write-error counter ---------------------------------------------
`ifdef CDC_CHAN_ARB_ERRCNT_EN
    logic [15:0] err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else if ((state == ST_RUN) && fifo_wrerr && (err_q != 16'hFFFF)) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign err_cnt = err_q;
`else
    logic unused_wrerr;

    assign unused_wrerr = fifo_wrerr;
    assign err_cnt      = '0;
`endif

endmodule

// File: tb/tb_cdc_chan_arb.sv
module tb_cdc_chan_arb;

    localparam int NR   = 4;
    localparam int DW   = 32;
    localparam int TW   = 2;
    localparam int RSTC = 8;
    localparam int RECC = 4;
    localparam int RUNAGE = RSTC + RECC;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*DW-1:0]  req_data = '0;
    logic [NR-1:0]     req_ready;
    logic              fifo_rst;
    logic              fifo_wren;
    logic [DW+TW-1:0]  fifo_di;
    logic              fifo_almostfull = 1'b0;
    logic              fifo_wrerr = 1'b0;
    logic              chan_up;
    logic [15:0]       err_cnt;

    cdc_chan_arb #(
        .NUM_REQ        (NR),
        .DATA_W         (DW),
        .RST_CYCLES     (RSTC),
        .RECOVER_CYCLES (RECC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .fifo_rst        (fifo_rst),
        .fifo_wren       (fifo_wren),
        .fifo_di         (fifo_di),
        .fifo_almostfull (fifo_almostfull),
        .fifo_wrerr      (fifo_wrerr),
        .chan_up         (chan_up),
        .err_cnt         (err_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the sequence is tracked as "cycles since the reset
    // sequence started"; phase follows from that age alone.
    int               m_age = 0;
    int               m_ptr = 0;
    bit               m_wv  = 1'b0;
    logic [DW+TW-1:0] m_di  = '0;
    int               m_err = 0;
    logic [DW-1:0]    dat [NR];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic fl, input logic [NR-1:0] v, input logic af, input logic we,
                         output logic [NR-1:0] o_ready, output logic o_wren,
                         output logic [TW-1:0] o_tag, output logic o_rst, output logic o_up);
        logic [NR-1:0] er;
        int g;
        flush = fl;
        req_valid = v;
        fifo_almostfull = af;
        fifo_wrerr = we;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = dat[i];
        @(negedge clk);
        er = '0;
        g = -1;
        if (m_age >= RUNAGE && !af && !fl) begin
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (m_ptr + k) % NR;
                if (v[i] && g < 0) g = i;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        chk("m_ready", 64'(req_ready), 64'(er));
        chk("m_fifo_rst", 64'(fifo_rst), 64'(m_age < RSTC));
        chk("m_wren", 64'(fifo_wren), 64'(m_wv && !fl));
        if (m_wv && !fl) chk("m_di", 64'(fifo_di), 64'(m_di));
        chk("m_chan_up", 64'(chan_up), 64'(m_age >= RUNAGE));
        chk("m_err_cnt", 64'(err_cnt), 64'(m_err));
        o_ready = req_ready;
        o_wren  = fifo_wren;
        o_tag   = fifo_di[DW+TW-1:DW];
        o_rst   = fifo_rst;
        o_up    = chan_up;
        @(posedge clk);
        #1;
        if (rst) begin
            m_age = 0; m_ptr = 0; m_wv = 1'b0; m_di = '0; m_err = 0;
        end else begin
`ifdef CDC_CHAN_ARB_ERRCNT_EN
            if (m_age >= RUNAGE && we && m_err < 65535) m_err++;
`endif
            m_wv = (g >= 0);
            if (g >= 0) begin
                m_di  = {TW'(g), dat[g]};
                m_ptr = (g + 1) % NR;
            end
            if (fl) begin
                m_age = 0;
                m_ptr = 0;
            end else if (m_age < 100000) begin
                m_age++;
            end
        end
        // Requesters only change payload once it has been taken or is idle.
        for (int i = 0; i < NR; i++) if (!v[i] || er[i]) dat[i] = $urandom;
    endtask

    typedef struct {
        logic [NR-1:0] v;
        logic          af;
        logic [NR-1:0] ready;
        logic          wren;
        logic [TW-1:0] tag;
    } vec_t;

    vec_t tbl [18];

    initial begin
        logic [NR-1:0] rd;
        logic wr, fr, up;
        logic [TW-1:0] tg;
        int rst_hi, up_at, wr_cnt, err_before;
        logic [NR-1:0] first_grant;

        tbl[0]  = '{4'hF, 1'b0, 4'h1, 1'b0, 2'd0};
        tbl[1]  = '{4'hF, 1'b0, 4'h2, 1'b1, 2'd0};
        tbl[2]  = '{4'hF, 1'b0, 4'h4, 1'b1, 2'd1};
        tbl[3]  = '{4'hF, 1'b0, 4'h8, 1'b1, 2'd2};
        tbl[4]  = '{4'hF, 1'b0, 4'h1, 1'b1, 2'd3};
        tbl[5]  = '{4'hF, 1'b1, 4'h0, 1'b1, 2'd0};
        tbl[6]  = '{4'hF, 1'b1, 4'h0, 1'b0, 2'd0};
        tbl[7]  = '{4'hF, 1'b1, 4'h0, 1'b0, 2'd0};
        tbl[8]  = '{4'hF, 1'b1, 4'h0, 1'b0, 2'd0};
        tbl[9]  = '{4'hF, 1'b1, 4'h0, 1'b0, 2'd0};
        tbl[10] = '{4'hF, 1'b0, 4'h2, 1'b0, 2'd0};
        tbl[11] = '{4'h0, 1'b0, 4'h0, 1'b1, 2'd1};
        tbl[12] = '{4'h0, 1'b0, 4'h0, 1'b0, 2'd0};
        tbl[13] = '{4'h1, 1'b0, 4'h1, 1'b0, 2'd0};
        tbl[14] = '{4'h4, 1'b0, 4'h4, 1'b1, 2'd0};
        tbl[15] = '{4'h5, 1'b0, 4'h1, 1'b1, 2'd2};
        tbl[16] = '{4'h5, 1'b0, 4'h4, 1'b1, 2'd0};
        tbl[17] = '{4'h0, 1'b0, 4'h0, 1'b1, 2'd2};

        for (int i = 0; i < NR; i++) dat[i] = $urandom;

        // Reset: valid requests must not be granted while rst is held.
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            cycle(1'b0, 4'hF, 1'b0, 1'b0, rd, wr, tg, fr, up);
            chk("reset_ready", 64'(rd), 64'h0);
            chk("reset_fifo_rst", 64'(fr), 64'h1);
            chk("reset_di", 64'(fifo_di), 64'h0);
        end
        rst = 1'b0;

        rst_hi = 0;
        up_at = -1;
        wr_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            cycle(1'b0, 4'h0, 1'b0, 1'b0, rd, wr, tg, fr, up);
            if (fr) rst_hi++;
            if (wr) wr_cnt++;
            if (up && up_at < 0) up_at = c;
        end
        chk("seq_rst_len", 64'(rst_hi), 64'd8);
        chk("seq_wren", 64'(wr_cnt), 64'd0);
        chk("seq_chan_up_at", 64'(up_at), 64'd12);

        // Fairness, backpressure, sparse requests.
        for (int r = 0; r < 18; r++) begin
            cycle(1'b0, tbl[r].v, tbl[r].af, 1'b0, rd, wr, tg, fr, up);
            chk($sformatf("tbl%0d_ready", r), 64'(rd), 64'(tbl[r].ready));
            chk($sformatf("tbl%0d_wren", r), 64'(wr), 64'(tbl[r].wren));
            if (tbl[r].wren) chk($sformatf("tbl%0d_tag", r), 64'(tg), 64'(tbl[r].tag));
        end

        // Flush in the cycle after a transfer and together with a new request.
        cycle(1'b0, 4'hF, 1'b0, 1'b0, rd, wr, tg, fr, up);
        chk("pre_flush_ready", 64'(rd), 64'h8);
        cycle(1'b1, 4'hF, 1'b0, 1'b0, rd, wr, tg, fr, up);
        chk("flush_ready", 64'(rd), 64'h0);
        chk("flush_wren", 64'(wr), 64'h0);
        rst_hi = 0;
        wr_cnt = 0;
        first_grant = '0;
        for (int c = 0; c < 13; c++) begin
            cycle(1'b0, 4'hF, 1'b0, 1'b0, rd, wr, tg, fr, up);
            if (fr) rst_hi++;
            if (wr) wr_cnt++;
            if (c == 12) first_grant = rd;
        end
        chk("flush_rst_len", 64'(rst_hi), 64'd8);
        chk("flush_no_wren", 64'(wr_cnt), 64'd0);
        chk("flush_ptr_zero", 64'(first_grant), 64'h1);

        // Write-error pulses, then a flush that must not clear the count.
        for (int c = 0; c < 3; c++) begin
            cycle(1'b0, 4'hF, 1'b0, 1'b1, rd, wr, tg, fr, up);
            cycle(1'b0, 4'hF, 1'b0, 1'b0, rd, wr, tg, fr, up);
        end
`ifdef CDC_CHAN_ARB_ERRCNT_EN
        chk("err_three", 64'(err_cnt), 64'd3);
`else
        chk("err_tied", 64'(err_cnt), 64'd0);
`endif
        err_before = int'(err_cnt);
        cycle(1'b1, 4'h0, 1'b0, 1'b0, rd, wr, tg, fr, up);
        for (int c = 0; c < 14; c++) cycle(1'b0, 4'h0, 1'b0, 1'b0, rd, wr, tg, fr, up);
`ifdef CDC_CHAN_ARB_ERRCNT_EN
        chk("err_after_flush", 64'(err_cnt), 64'd3);
`else
        chk("err_after_flush", 64'(err_cnt), 64'(0));
`endif

        // Randomised traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            logic fl, af, we;
            logic [NR-1:0] v;
            fl = ($urandom_range(0, 99) == 0);
            af = ($urandom_range(0, 3) == 0);
            we = ($urandom_range(0, 9) == 0);
            v  = NR'($urandom);
            cycle(fl, v, af, we, rd, wr, tg, fr, up);
            chk("rand_onehot", 64'($countones(rd) <= 1), 64'd1);
        end

`ifdef CDC_CHAN_ARB_ERRCNT_EN
        for (int c = 0; c < 14; c++) cycle(1'b0, 4'h0, 1'b0, 1'b0, rd, wr, tg, fr, up);
        for (int c = 0; c < 65540; c++) cycle(1'b0, 4'h0, 1'b0, 1'b1, rd, wr, tg, fr, up);
        chk("err_sat", 64'(err_cnt), 64'hFFFF);
        cycle(1'b0, 4'h0, 1'b0, 1'b1, rd, wr, tg, fr, up);
        cycle(1'b0, 4'h0, 1'b0, 1'b0, rd, wr, tg, fr, up);
        chk("err_sat_hold", 64'(err_cnt), 64'hFFFF);
`else
        chk("err_before_rand", 64'(err_before), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
